// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
// Holds the NOP encoding, the default bundle widths for each
// inter-stage register, and the occupancy encoding with a helper
// that turns the two valid bits into an occupancy code.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default bundle widths for the classic five-stage boundaries.
  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 128;
  localparam int EXMEM_W = 96;
  localparam int MEMWB_W = 96;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_encode(input logic main_valid,
                                            input logic skid_valid);
    logic [1:0] occ;
    case ({main_valid, skid_valid})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_TWO;
      default: occ = OCC_ONE;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, counts on posedge
//   rst   - synchronous active-low reset, clears count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a one-entry skid behind the
// main output register, so upstream ready never depends on downstream
// ready. Flush squashes everything held; debug counters track stall
// and flush cycles.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   flush               - synchronous squash of held beats
//   in_valid/in_ready/in_data    - upstream handshake and bundle
//   out_valid/out_ready/out_data - downstream handshake and bundle
//   occupancy           - registered count of beats held (0..2)
//   stall_cnt           - saturating count of out_valid && !out_ready cycles
//   flush_cnt           - saturating count of flush cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  logic              nxt_out_valid;
  logic [DATA_W-1:0] nxt_out_data;
  logic              nxt_skid_valid;
  logic [DATA_W-1:0] nxt_skid_data;

  logic in_fire;
  logic out_fire;

  // Ready is purely a function of skid state; a full skid is the only
  // reason to refuse a beat.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    nxt_out_valid  = out_valid;
    nxt_out_data   = out_data;
    nxt_skid_valid = skid_valid;
    nxt_skid_data  = skid_data;
    if (flush) begin
      // Any out_fire this cycle already completed downstream; an
      // accepted in_fire is dropped.
      nxt_out_valid  = 1'b0;
      nxt_out_data   = BUBBLE;
      nxt_skid_valid = 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        // Oldest beat lives in the skid; promote it first to keep FIFO order.
        nxt_out_valid  = 1'b1;
        nxt_out_data   = skid_data;
        nxt_skid_valid = in_fire;
        if (in_fire) nxt_skid_data = in_data;
      end else if (in_fire) begin
        nxt_out_valid = 1'b1;
        nxt_out_data  = in_data;
      end else begin
        nxt_out_valid = 1'b0;
        nxt_out_data  = BUBBLE;
      end
    end else if (in_fire) begin
      // Main is stalled: park the incoming beat; in_ready drops next cycle.
      nxt_skid_valid = 1'b1;
      nxt_skid_data  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= BUBBLE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE;
      occupancy  <= OCC_EMPTY;
    end else begin
      out_valid  <= nxt_out_valid;
      out_data   <= nxt_out_data;
      skid_valid <= nxt_skid_valid;
      skid_data  <= nxt_skid_data;
      occupancy  <= occ_encode(nxt_out_valid, nxt_skid_valid);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: a default-width instance (a)
// and a CNT_W=2 instance (b) for counter saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt, flush_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset held 2 cycles with a beat offered
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_occ",       occupancy, 0);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_flush",     flush_cnt, 0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_in_ready",  in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Latency 1 and back-to-back throughput
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h0000_0004_8C01_0000;
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data",  out_data, 64'h0000_0004_8C01_0000);
    for (int i = 0; i < 8; i++) begin
      in_data = 64'h100 + 64'(i);
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data",  out_data, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_data",  out_data, 0);
    chk("b2b_stall",   stall_cnt, 0);

    // Stall: A then B fill main and skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    step();
    chk("stA_occ", occupancy, 1);
    in_data = 64'hB;
    step();
    in_valid = 1'b0;
    chk("stB_occ",   occupancy, 2);
    chk("stB_ready", in_ready, 0);
    chk("stB_data",  out_data, 64'hA);
    step(); step(); step(); step();
    chk("st_cnt5",  stall_cnt, 5);
    chk("st_hold",  out_data, 64'hA);
    out_ready = 1'b1;
    #1;
    chk("rel_A",     out_data, 64'hA);
    step();
    chk("rel_B",     out_data, 64'hB);
    chk("rel_Bv",    out_valid, 1);
    chk("rel_ready", in_ready, 1);
    chk("rel_occ",   occupancy, 1);
    chk("rel_stall", stall_cnt, 5);
    step();
    chk("rel_empty", out_valid, 0);

    // Flush at occupancy 2 with C offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD;
    step();
    in_data = 64'hE;
    step();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1; in_data = 64'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_data",  out_data, 0);
    chk("fl_occ",   occupancy, 0);
    chk("fl_cnt",   flush_cnt, 1);
    chk("fl_stall", stall_cnt, 7);
    out_ready = 1'b1;
    step();
    chk("fl_noC1", out_valid, 0);
    step();
    chk("fl_noC2", out_valid, 0);

    // Saturation on the CNT_W=2 instance
    b_in_valid = 1'b1; b_in_data = 64'h55;
    step();
    b_in_valid = 1'b0;
    chk("sat_start", b_stall_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_stall", b_stall_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    b_flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_flush", b_flush_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    b_flush = 1'b0;

    // Reset mid-stall at occupancy 2
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hF;
    step();
    in_data = 64'h6;
    step();
    in_valid = 1'b0;
    chk("mr_pre_occ", occupancy, 2);
    rst = 1'b0;
    step();
    chk("mr_valid", out_valid, 0);
    chk("mr_data",  out_data, 0);
    chk("mr_occ",   occupancy, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_flush", flush_cnt, 0);
    rst = 1'b1; out_ready = 1'b1;
    step();
    chk("mr_nostale1", out_valid, 0);
    step();
    chk("mr_nostale2", out_valid, 0);
    chk("mr_nostale_d", out_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
